// File: rtl/md_ctrl_if.sv
// rtl/md_ctrl_if.sv - request and HI/LO write-port bundle for the mult/div sequencer
interface md_ctrl_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;
  logic        busy;
  logic        done;
  logic        hi_we;
  logic [31:0] hi_d;
  logic        lo_we;
  logic [31:0] lo_d;

  modport master (
    output start, op, a, b, cancel,
    input  busy, done, hi_we, hi_d, lo_we, lo_d
  );

  modport slave (
    input  start, op, a, b, cancel,
    output busy, done, hi_we, hi_d, lo_we, lo_d
  );
endinterface

// File: rtl/md_ctrl.sv
// rtl/md_ctrl.sv - HI/LO sequencer: fixed-latency MULT/MULTU/DIV/DIVU, single-cycle MTHI/MTLO
module md_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic      clk,
  input  logic      reset,
  md_ctrl_if.slave  md
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] MULT_LAST = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, WB} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   res_hi_q, res_hi_d;
  logic [31:0]   res_lo_q, res_lo_d;
  logic          dz_q, dz_d;
  logic          busy_q, busy_d;
  logic          wb_q, wb_d;

  logic          take, accept, is_div, mt_hi, mt_lo, wb_ok;
  logic          sgn_div;
  logic [31:0]   ua, ub, ub_safe, quo, rem, quo_s, rem_s;
  logic [63:0]   prod;

  // Division runs on magnitudes so the 0x80000000 / -1 case wraps back to 0x80000000 naturally.
  always_comb begin
    sgn_div = (md.op == OP_DIV);
    ua      = (sgn_div && md.a[31]) ? -md.a : md.a;
    ub      = (sgn_div && md.b[31]) ? -md.b : md.b;
    ub_safe = (ub == 32'd0) ? 32'd1 : ub;
    quo     = ua / ub_safe;
    rem     = ua % ub_safe;
    quo_s   = (sgn_div && (md.a[31] ^ md.b[31])) ? -quo : quo;
    rem_s   = (sgn_div && md.a[31]) ? -rem : rem;
    if (md.op == OP_MULT)
      prod = {{32{md.a[31]}}, md.a} * {{32{md.b[31]}}, md.b};
    else
      prod = {32'd0, md.a} * {32'd0, md.b};
  end

  always_comb begin
    take   = reset && (state_q == IDLE) && md.start && !md.cancel;
    accept = take && (md.op >= OP_MULT) && (md.op <= OP_DIVU);
    is_div = (md.op == OP_DIV) || (md.op == OP_DIVU);
    mt_hi  = take && (md.op == OP_MTHI);
    mt_lo  = take && (md.op == OP_MTLO);

    state_d  = state_q;
    cnt_d    = cnt_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    dz_d     = dz_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = BUSY;
          cnt_d   = is_div ? DIV_LAST : MULT_LAST;
          dz_d    = is_div && (md.b == 32'd0);
          if (is_div) begin
            res_hi_d = rem_s;
            res_lo_d = quo_s;
          end else begin
            res_hi_d = prod[63:32];
            res_lo_d = prod[31:0];
          end
        end
      end
      BUSY: begin
        if (md.cancel)
          state_d = IDLE;
        else if (cnt_q == '0)
          state_d = WB;
        else
          cnt_d = cnt_q - 1'b1;
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    wb_d   = (state_d == WB);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      dz_q     <= 1'b0;
      busy_q   <= 1'b0;
      wb_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      dz_q     <= dz_d;
      busy_q   <= busy_d;
      wb_q     <= wb_d;
    end
  end

  // A flush arriving in the writeback cycle still has to kill the write that same cycle.
  assign wb_ok    = wb_q && !md.cancel;
  assign md.busy  = busy_q;
  assign md.done  = wb_ok;
  assign md.hi_we = (wb_ok && !dz_q) || mt_hi;
  assign md.lo_we = (wb_ok && !dz_q) || mt_lo;
  assign md.hi_d  = mt_hi ? md.a : res_hi_q;
  assign md.lo_d  = mt_lo ? md.a : res_lo_q;

endmodule

// File: tb/tb_md_ctrl.sv
// tb/tb_md_ctrl.sv - randomized HI/LO sequencer bench against an arithmetic reference model
module tb_md_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam logic [2:0] OP_RSVD  = 3'd7;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  md_ctrl_if md ();

  md_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (md)
  );

  int vectors = 0;
  int miscompares = 0;

  // The architectural HI/LO pair, written only through the sequencer's write ports.
  logic [31:0] reg_hi = 32'd0;
  logic [31:0] reg_lo = 32'd0;
  always @(posedge clk) begin
    if (md.hi_we) reg_hi <= md.hi_d;
    if (md.lo_we) reg_lo <= md.lo_d;
  end

  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo, output bit dz);
    longint sa, sb, sp;
    longint unsigned up;
    hi = m_hi;
    lo = m_lo;
    dz = 1'b0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      OP_MULT: begin
        sp = sa * sb;
        hi = sp[63:32];
        lo = sp[31:0];
      end
      OP_MULTU: begin
        up = 64'(a) * 64'(b);
        hi = up[63:32];
        lo = up[31:0];
      end
      OP_DIV: begin
        if (b == 32'd0) dz = 1'b1;
        else begin
          sp = sa / sb;
          lo = sp[31:0];
          sp = sa % sb;
          hi = sp[31:0];
        end
      end
      OP_DIVU: begin
        if (b == 32'd0) dz = 1'b1;
        else begin
          lo = a / b;
          hi = a % b;
        end
      end
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic int latency(input logic [2:0] op);
    return (op == OP_MULT || op == OP_MULTU) ? MC : DC;
  endfunction

  // All tasks enter and leave 1 time unit after a rising edge.
  task automatic do_muldiv(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input bit noise);
    logic [31:0] eh, el;
    bit dz;
    int n;
    model(op, a, b, eh, el, dz);
    n = latency(op);
    md.start = 1'b1; md.op = op; md.a = a; md.b = b; md.cancel = 1'b0;
    @(negedge clk);
    check("accept_cycle", {md.busy, md.done, md.hi_we, md.lo_we}, 4'b0000);
    @(posedge clk); #1;
    for (int c = 1; c <= n + 1; c++) begin
      md.start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      md.op = 3'($urandom_range(0, 7));
      md.a = $urandom;
      md.b = $urandom;
      @(negedge clk);
      if (c <= n) begin
        check("busy_phase", {md.busy, md.done, md.hi_we, md.lo_we}, 4'b1000);
      end else begin
        check("wb_ctl", {md.busy, md.done, md.hi_we, md.lo_we}, {1'b1, 1'b1, ~dz, ~dz});
        if (!dz) check("wb_data", {md.hi_d, md.lo_d}, {eh, el});
      end
      @(posedge clk); #1;
    end
    md.start = 1'b0;
    if (!dz) begin
      m_hi = eh;
      m_lo = el;
    end
    @(negedge clk);
    check("after_wb_busy", {md.busy, md.done, md.hi_we, md.lo_we}, 4'b0000);
    check("hilo_regs", {reg_hi, reg_lo}, {m_hi, m_lo});
    @(posedge clk); #1;
  endtask

  task automatic do_mt(input logic [2:0] op, input logic [31:0] a);
    md.start = 1'b1; md.op = op; md.a = a; md.b = $urandom; md.cancel = 1'b0;
    @(negedge clk);
    if (op == OP_MTHI) begin
      check("mthi_ctl", {md.busy, md.done, md.hi_we, md.lo_we}, 4'b0010);
      check("mthi_data", md.hi_d, a);
      m_hi = a;
    end else if (op == OP_MTLO) begin
      check("mtlo_ctl", {md.busy, md.done, md.hi_we, md.lo_we}, 4'b0001);
      check("mtlo_data", md.lo_d, a);
      m_lo = a;
    end else begin
      check("nop_ctl", {md.busy, md.done, md.hi_we, md.lo_we}, 4'b0000);
    end
    @(posedge clk); #1;
    md.start = 1'b0;
    @(negedge clk);
    check("mt_idle", md.busy, 1'b0);
    check("mt_regs", {reg_hi, reg_lo}, {m_hi, m_lo});
    @(posedge clk); #1;
  endtask

  // Starts op, flushes it in cycle k (1..N+1), then immediately issues a MULT.
  task automatic do_cancel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int k);
    md.start = 1'b1; md.op = op; md.a = a; md.b = b; md.cancel = 1'b0;
    @(posedge clk); #1;
    md.start = 1'b0;
    for (int c = 1; c <= k; c++) begin
      md.cancel = (c == k);
      @(negedge clk);
      check("cancel_phase", {md.busy, md.done, md.hi_we, md.lo_we}, 4'b1000);
      @(posedge clk); #1;
    end
    md.cancel = 1'b0;
    do_muldiv(OP_MULT, rnd32(), rnd32(), 1'b0);
  endtask

  task automatic do_idle_cancel(input logic [2:0] op, input logic [31:0] a);
    md.start = 1'b1; md.op = op; md.a = a; md.b = $urandom; md.cancel = 1'b1;
    @(negedge clk);
    check("idle_cancel_ctl", {md.busy, md.done, md.hi_we, md.lo_we}, 4'b0000);
    @(posedge clk); #1;
    md.start = 1'b0; md.cancel = 1'b0;
    @(negedge clk);
    check("idle_cancel_busy", md.busy, 1'b0);
    check("idle_cancel_regs", {reg_hi, reg_lo}, {m_hi, m_lo});
    @(posedge clk); #1;
  endtask

  task automatic do_reset_mid(input int at_cycle);
    md.start = 1'b1; md.op = OP_DIV; md.a = $urandom; md.b = $urandom | 32'd1; md.cancel = 1'b0;
    @(posedge clk); #1;
    md.start = 1'b0;
    for (int c = 1; c < at_cycle; c++) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    md.start = 1'b1; md.op = OP_MTLO; md.a = $urandom;
    #1;
    check("rst_mid_ctl", {md.busy, md.done, md.hi_we, md.lo_we}, 4'b0000);
    check("rst_mid_data", {md.hi_d, md.lo_d}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    md.start = 1'b0;
    @(negedge clk);
    check("rst_release_busy", md.busy, 1'b0);
    check("rst_regs", {reg_hi, reg_lo}, {m_hi, m_lo});
    @(posedge clk); #1;
  endtask

  initial begin
    int kind;
    logic [2:0] op;
    md.start = 1'b1; md.op = OP_MTHI; md.a = 32'hDEAD_BEEF; md.b = 32'd0; md.cancel = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("reset_ctl", {md.busy, md.done, md.hi_we, md.lo_we}, 4'b0000);
    check("reset_data", {md.hi_d, md.lo_d}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    md.start = 1'b0;
    @(negedge clk);
    check("idle_after_reset", md.busy, 1'b0);
    @(posedge clk); #1;

    do_muldiv(OP_MULT,  32'hFFFF_FFFE, 32'd3, 1'b0);
    check("mult_neg_hilo", {m_hi, m_lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    do_muldiv(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b1);
    check("multu_hilo", {m_hi, m_lo}, 64'h0000_0001_FFFF_FFFE);
    do_muldiv(OP_DIV,   32'hFFFF_FFF9, 32'd2, 1'b1);
    check("div_neg_hilo", {m_hi, m_lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_muldiv(OP_DIVU,  32'd7, 32'd0, 1'b1);
    check("divu_zero_hilo", {m_hi, m_lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_muldiv(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("div_ovf_hilo", {m_hi, m_lo}, 64'h0000_0000_8000_0000);
    do_mt(OP_MTHI, 32'h1234_5678);
    do_mt(OP_MTLO, 32'h9ABC_DEF0);
    do_mt(OP_NONE, 32'h5555_5555);
    do_mt(OP_RSVD, 32'hAAAA_AAAA);
    do_cancel(OP_DIV, 32'd100, 32'd7, 4);
    do_cancel(OP_MULT, 32'd9, 32'd9, MC + 1);
    do_idle_cancel(OP_MTHI, 32'h0BAD_F00D);
    do_idle_cancel(OP_MULT, 32'd5);
    do_reset_mid(3);
    do_muldiv(OP_MULT, 32'd2, 32'd3, 1'b0);
    check("mult_after_reset_lo", m_lo, 32'd6);

    for (int i = 0; i < 80; i++) begin
      kind = $urandom_range(0, 9);
      case (kind)
        0, 1, 2, 3: do_muldiv(3'(kind + 1), rnd32(), rnd32(), 1'($urandom_range(0, 1)));
        4: do_mt(OP_MTHI, $urandom);
        5: do_mt(OP_MTLO, $urandom);
        6: do_mt($urandom_range(0, 1) ? OP_NONE : OP_RSVD, $urandom);
        7: begin
          op = 3'($urandom_range(1, 4));
          do_cancel(op, rnd32(), rnd32(), $urandom_range(1, latency(op) + 1));
        end
        8: do_muldiv($urandom_range(0, 1) ? OP_DIV : OP_DIVU, rnd32(), 32'd0, 1'b1);
        default: do_idle_cancel(3'($urandom_range(1, 6)), $urandom);
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
